// File: rtl/memwb_skid_reg.sv
// memwb_skid_reg: MEM->WB pipeline register with valid/ready skid buffer, flush, write gating and debug counters
module memwb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] readdataM,
  input  logic [REG_W-1:0]  writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] aluoutW,
  output logic [DATA_W-1:0] readdataW,
  output logic [REG_W-1:0]  writeregW,
  output logic              regwriteW,
  output logic              memtoregW,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state;
  logic [DATA_W-1:0] alu_s, rd_s;
  logic [REG_W-1:0] wr_s;
  logic rw_s, mr_s, rw_m;
  logic in_fire, out_fire, load_main, load_skid, pop_skid;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign regwriteW = out_valid & rw_m & (writeregW != '0);
  assign load_main = !flush & in_fire & (state == EMPTY || (state == ONE && out_fire));
  assign load_skid = !flush & in_fire & state == ONE & !out_fire;
  assign pop_skid  = !flush & state == TWO & out_fire;
  // occupancy: EMPTY/ONE/TWO, flush drops everything including a same-cycle accept
  always_ff @(posedge clk)
    if (reset || flush) state <= EMPTY;
    else
      case (state)
        EMPTY:   state <= in_fire ? ONE : EMPTY;
        ONE:     state <= (in_fire & !out_fire) ? TWO : (!in_fire & out_fire) ? EMPTY : ONE;
        default: state <= out_fire ? ONE : TWO;
      endcase
  // main entry loads from input directly or from the skid entry when it drains
  always_ff @(posedge clk)
    if (reset) begin
      aluoutW   <= '0;
      readdataW <= '0;
      writeregW <= '0;
      rw_m      <= 1'b0;
      memtoregW <= 1'b0;
    end else if (load_main || pop_skid) begin
      aluoutW   <= pop_skid ? alu_s : aluoutM;
      readdataW <= pop_skid ? rd_s  : readdataM;
      writeregW <= pop_skid ? wr_s  : writeregM;
      rw_m      <= pop_skid ? rw_s  : regwriteM;
      memtoregW <= pop_skid ? mr_s  : memtoregM;
    end
  // skid entry captures the input accepted while main is stalled
  always_ff @(posedge clk)
    if (reset) begin
      alu_s <= '0;
      rd_s  <= '0;
      wr_s  <= '0;
      rw_s  <= 1'b0;
      mr_s  <= 1'b0;
    end else if (load_skid) begin
      alu_s <= aluoutM;
      rd_s  <= readdataM;
      wr_s  <= writeregM;
      rw_s  <= regwriteM;
      mr_s  <= memtoregM;
    end
  // saturating debug counters, cleared only by reset
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule

// File: tb/tb_memwb_skid_reg.sv
// tb_memwb_skid_reg: scoreboard bench for the MEM->WB skid register
module tb_memwb_skid_reg;
  localparam int DW = 32, RW = 5, CW = 4;
  logic clk = 1'b0, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] aluoutM, readdataM, aluoutW, readdataW;
  logic [RW-1:0] writeregM, writeregW;
  logic regwriteM, memtoregM, regwriteW, memtoregW;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [70:0] q[$];
  logic [70:0] e;
  int n_checks = 0, n_pass = 0;

  memwb_skid_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluoutM(aluoutM), .readdataM(readdataM), .writeregM(writeregM), .regwriteM(regwriteM),
    .memtoregM(memtoregM), .out_valid(out_valid), .out_ready(out_ready), .aluoutW(aluoutW),
    .readdataW(readdataW), .writeregW(writeregW), .regwriteW(regwriteW), .memtoregW(memtoregW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [70:0] pack(input logic [DW-1:0] a, input logic [DW-1:0] r,
                                       input logic [RW-1:0] w, input logic rw, input logic mr);
    return {a, r, w, rw & (w != '0), mr};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [RW-1:0] w, input logic rw);
    in_valid  = v;
    aluoutM   = a;
    readdataM = ~a;
    writeregM = w;
    regwriteM = rw;
    memtoregM = a[0];
  endtask

  task automatic step();
    logic fi, fo;
    fi = in_valid & in_ready & !flush & !reset;
    fo = out_valid & out_ready & !flush & !reset;
    if (fo) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_entry", {aluoutW, readdataW, writeregW, regwriteW, memtoregW}, e);
      end
    end
    if (reset || flush) q.delete();
    else if (fi) q.push_back(pack(aluoutM, readdataM, writeregM, regwriteM, memtoregM));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_data"}, {aluoutW, readdataW, writeregW, regwriteW, memtoregW}, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0);
    step();
    drive(1, 32'hdead, 3, 1);
    step();
    chk("reset_hold_in_ready", in_ready, 1);
    reset = 1'b0;
    drive(0, 0, 0, 0);
    chk_reset_state("reset");
    step();
    chk("reset_ignored_input", out_valid, 0);
    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(i * 16), RW'(i), 1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_ready", in_ready, 1);
      chk("stream_alu", aluoutW, i * 16);
    end
    drive(0, 0, 0, 0);
    step();
    chk("stream_drained", out_valid, 0);
    chk("stream_stall_cnt", stall_cnt, 0);
    // back-pressure
    out_ready = 1'b0;
    drive(1, 32'h11, 7, 1);
    step();
    chk("bp_ready_after_a", in_ready, 1);
    drive(1, 32'h22, 8, 1);
    step();
    chk("bp_ready_after_b", in_ready, 0);
    chk("bp_alu_a", aluoutW, 32'h11);
    drive(0, 0, 0, 0);
    step();
    step();
    chk("bp_alu_stable", aluoutW, 32'h11);
    chk("bp_stall_cnt", stall_cnt, 3);
    chk("bp_ready_held", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_alu_b", aluoutW, 32'h22);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_drained", out_valid, 0);
    // register-0 write gating
    drive(1, 32'h55, 0, 1);
    step();
    chk("gate_r0", regwriteW, 0);
    drive(1, 32'h56, 5, 1);
    step();
    chk("gate_r5_we", regwriteW, 1);
    chk("gate_r5_reg", writeregW, 5);
    drive(0, 0, 0, 0);
    step();
    chk("gate_bubble_we", regwriteW, 0);
    // flush in TWO with a same-cycle input
    out_ready = 1'b0;
    drive(1, 32'h77, 9, 1);
    step();
    drive(1, 32'h88, 10, 1);
    step();
    chk("flush_pre_two", in_ready, 0);
    flush = 1'b1;
    drive(1, 32'h99, 11, 1);
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_cnt", flush_cnt, 1);
    chk("flush_stall_cnt", stall_cnt, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_output", out_valid, 0);
    end
    // reset in TWO
    out_ready = 1'b0;
    drive(1, 32'haa, 12, 1);
    step();
    drive(1, 32'hbb, 13, 1);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    step();
    reset = 1'b0;
    chk_reset_state("midreset");
    out_ready = 1'b1;
    drive(1, 32'hcc, 14, 0);
    step();
    chk("midreset_latency", out_valid, 1);
    chk("midreset_alu", aluoutW, 32'hcc);
    drive(0, 0, 0, 0);
    step();
    // stall counter saturation
    out_ready = 1'b0;
    drive(1, 32'hdd, 15, 1);
    step();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_alu_stable", aluoutW, 32'hdd);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("final_queue_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
